ser_tx_seq: RTL and testbench

Bus-write-driven serial transmitter for the 93xx I/O window, mirroring the bus-read serial decode logic at the other end of the same link. The CPU selects the block with SSER low, BA13 low, BA12 high and BR_W low, and issues one of three commands on BA7..BA4. The block double-buffers a data byte and shifts it out as an asynchronous frame on SDWR: start bit, 8 data bits LSB first, optional parity, stop bit. Busy, buffer-full and overrun status are exported for the status-read path.

---
 rtl/ser_tx_seq.sv | 211 +++++++++++++++++++++
 tb/tb_ser_tx_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_tx_seq.sv
// Bus-write-driven async serial transmitter (start, 8 data LSB first, stop) with a double-buffered byte.
// Define SER_TX_PARITY_EN to add an odd parity bit (~^data) before the stop bit.
module ser_tx_seq #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       SSER,
   input  logic       BA13,
   input  logic       BA12,
   input  logic [3:0] BA,
   input  logic       BR_W,
   input  logic [7:0] BD,
   output logic       SDWR,
   output logic       SBSY,
   output logic       SFUL,
   output logic       SOVR
);

   localparam int unsigned      CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);

   localparam logic [3:0] CMD_LOAD  = 4'h0;
   localparam logic [3:0] CMD_GO    = 4'h1;
   localparam logic [3:0] CMD_ABORT = 4'h2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
`ifdef SER_TX_PARITY_EN
      ST_PAR   = 3'd3,
`endif
      ST_STOP  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic             acc_q, acc_d;
   logic             go_pend_q, go_pend_d;
   logic             sful_q, sful_d;
   logic             sovr_q, sovr_d;
   logic             sbsy_q, sbsy_d;
   logic             sdwr_q, sdwr_d;
   logic [7:0]       hold_q, hold_d;
   logic [7:0]       shift_q, shift_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
`ifdef SER_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   logic acc, cmd_edge, cmd_load, cmd_go, cmd_abort;
   logic bit_end, start_now;

   // One command per bus cycle: only the first cycle of a qualifying write acts.
   assign acc       = ~SSER & ~BA13 & BA12 & ~BR_W;
   assign cmd_edge  = acc & ~acc_q;
   assign cmd_load  = cmd_edge && (BA == CMD_LOAD);
   assign cmd_go    = cmd_edge && (BA == CMD_GO);
   assign cmd_abort = cmd_edge && (BA == CMD_ABORT);
   assign bit_end   = (baud_q == BAUD_LAST);
   assign start_now = (state_q == ST_IDLE) && go_pend_q && sful_q;

   always_comb begin
      // NOTE: every _d starts from its _q so no branch can leave a value unassigned and infer a latch.
      state_d   = state_q;
      acc_d     = acc;
      go_pend_d = go_pend_q;
      sful_d    = sful_q;
      sovr_d    = sovr_q;
      sbsy_d    = sbsy_q;
      sdwr_d    = sdwr_q;
      hold_d    = hold_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      baud_d    = bit_end ? '0 : baud_q + BAUD_ONE;
`ifdef SER_TX_PARITY_EN
      par_d     = par_q;
`endif

      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            sdwr_d = 1'b1;
            sbsy_d = 1'b0;
            if (start_now) begin
               state_d   = ST_START;
               shift_d   = hold_q;
               sful_d    = 1'b0;
               go_pend_d = 1'b0;
               bit_cnt_d = '0;
               sdwr_d    = 1'b0;
               sbsy_d    = 1'b1;
`ifdef SER_TX_PARITY_EN
               par_d     = ~^hold_q;
`endif
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               sdwr_d  = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_d   = {1'b0, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
`ifdef SER_TX_PARITY_EN
                  state_d = ST_PAR;
                  sdwr_d  = par_q;
`else
                  state_d = ST_STOP;
                  sdwr_d  = 1'b1;
`endif
               end else begin
                  sdwr_d = shift_q[1];
               end
            end
         end
`ifdef SER_TX_PARITY_EN
         ST_PAR: begin
            if (bit_end) begin
               state_d = ST_STOP;
               sdwr_d  = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               state_d = ST_IDLE;
               sdwr_d  = 1'b1;
               sbsy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sdwr_d  = 1'b1;
            sbsy_d  = 1'b0;
            baud_d  = '0;
         end
      endcase

      // A LOAD coinciding with the shifter taking the old byte refills the buffer without overrun.
      if (cmd_load) begin
         if (!sful_q || start_now) begin
            hold_d = BD;
            sful_d = 1'b1;
         end else begin
            sovr_d = 1'b1;
         end
      end

      if (cmd_go) begin
         go_pend_d = 1'b1;
      end

      if (cmd_abort) begin
         state_d   = ST_IDLE;
         sdwr_d    = 1'b1;
         sbsy_d    = 1'b0;
         sful_d    = 1'b0;
         sovr_d    = 1'b0;
         go_pend_d = 1'b0;
         baud_d    = '0;
         bit_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state_q   <= ST_IDLE;
         acc_q     <= 1'b0;
         go_pend_q <= 1'b0;
         sful_q    <= 1'b0;
         sovr_q    <= 1'b0;
         sbsy_q    <= 1'b0;
         sdwr_q    <= 1'b1;
         baud_q    <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         go_pend_q <= go_pend_d;
         sful_q    <= sful_d;
         sovr_q    <= sovr_d;
         sbsy_q    <= sbsy_d;
         sdwr_q    <= sdwr_d;
         baud_q    <= baud_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // NOTE: data registers carry no reset; they are only observed after SFUL or a frame start qualifies them.
   always_ff @(posedge clk) begin
      hold_q  <= hold_d;
      shift_q <= shift_d;
`ifdef SER_TX_PARITY_EN
      par_q   <= par_d;
`endif
   end

   assign SDWR = sdwr_q;
   assign SBSY = sbsy_q;
   assign SFUL = sful_q;
   assign SOVR = sovr_q;

endmodule

// File: tb/tb_ser_tx_seq.sv
// Scoreboard bench for ser_tx_seq: stimulus pushes expected frames, a monitor decodes SDWR and compares.
// Frame length follows SER_TX_PARITY_EN so the same bench covers both builds.
module tb_ser_tx_seq;

   localparam int CPB = 4;
`ifdef SER_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam logic [3:0] C_LOAD  = 4'h0;
   localparam logic [3:0] C_GO    = 4'h1;
   localparam logic [3:0] C_ABORT = 4'h2;

   logic       clk, rst, SSER, BA13, BA12, BR_W;
   logic [3:0] BA;
   logic [7:0] BD;
   logic       SDWR, SBSY, SFUL, SOVR;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   typedef struct {
      logic [10:0] bits;
      bit          cut;
      int          start;
   } exp_t;
   exp_t exp_q[$];

   ser_tx_seq #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .SSER(SSER), .BA13(BA13), .BA12(BA12), .BA(BA),
      .BR_W(BR_W), .BD(BD), .SDWR(SDWR), .SBSY(SBSY), .SFUL(SFUL), .SOVR(SOVR)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Frame bit i is the i-th level on the line; unused upper bits are 1.
   function automatic logic [10:0] frame_of(input logic [7:0] d);
      logic [10:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = d;
`ifdef SER_TX_PARITY_EN
      f[9]   = ~^d;
`endif
      return f;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_cyc(input int t);
      while (cyc < t) tick(1);
   endtask

   task automatic bus(input logic sser, input logic ba13, input logic ba12, input logic brw,
                      input logic [3:0] ba, input logic [7:0] bd, input int len);
      SSER = sser; BA13 = ba13; BA12 = ba12; BR_W = brw; BA = ba; BD = bd;
      tick(len);
      SSER = 1'b1; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b0; BA = 4'hF; BD = 8'h00;
   endtask

   task automatic cmd(input logic [3:0] code, input logic [7:0] data);
      bus(1'b0, 1'b0, 1'b1, 1'b0, code, data, 1);
      tick(1);
   endtask

   task automatic drain(input string name, input int budget);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || SBSY !== 1'b0) && t < budget) begin
         tick(1);
         t++;
      end
      check(name, 32'(t < budget), 32'd1);
   endtask

   // Monitor: decodes each frame from its falling start edge, sampling every cycle of every bit.
   initial begin : monitor
      logic prev;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev === 1'b1 && SDWR === 1'b0) begin
            logic [10:0] fr;
            bit          cut, glitch;
            int          st;
            exp_t        e;
            fr = '1; cut = 1'b0; glitch = 1'b0; st = cyc;
            for (int b = 0; b < NB && !cut; b++) begin
               for (int c = 0; c < CPB && !cut; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (SBSY !== 1'b1) cut = 1'b1;
                  else if (c == 0) fr[b] = SDWR;
                  else if (SDWR !== fr[b]) glitch = 1'b1;
               end
            end
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_frame: frame at cycle %0d, queue empty", st);
            end else begin
               e = exp_q.pop_front();
               check("frame_start_cycle", st, e.start);
               check("frame_cut", 32'(cut), 32'(e.cut));
               if (!e.cut && !cut) begin
                  check("frame_bits", 32'(fr), 32'(e.bits));
                  check("frame_stable", 32'(glitch), 32'd0);
               end
            end
         end
         prev = SDWR;
      end
   end

   initial begin : stim
      int n, s, s2;
      rst = 1'b1;
      SSER = 1'b1; BA13 = 1'b0; BA12 = 1'b1; BR_W = 1'b0; BA = 4'hF; BD = 8'h00;
      tick(2);
      check("rst_sdwr", SDWR, 1);
      check("rst_sbsy", SBSY, 0);
      check("rst_sful", SFUL, 0);
      check("rst_sovr", SOVR, 0);
      rst = 1'b0;
      tick(2);

      // LOAD code on accesses that do not select the block
      bus(1'b0, 1'b0, 1'b1, 1'b1, C_LOAD, 8'h5A, 2); tick(1);
      check("ign_brw_sful", SFUL, 0);
      bus(1'b1, 1'b0, 1'b1, 1'b0, C_LOAD, 8'h5A, 2); tick(1);
      check("ign_sser_sful", SFUL, 0);
      bus(1'b0, 1'b1, 1'b1, 1'b0, C_LOAD, 8'h5A, 2); tick(1);
      check("ign_ba13_sful", SFUL, 0);
      bus(1'b0, 1'b0, 1'b0, 1'b0, C_LOAD, 8'h5A, 2); tick(1);
      check("ign_ba12_sful", SFUL, 0);

      // Long access loads once; a further LOAD overruns and leaves hold alone
      bus(1'b0, 1'b0, 1'b1, 1'b0, C_LOAD, 8'hA5, 6); tick(1);
      check("held_load_sful", SFUL, 1);
      check("held_load_sovr", SOVR, 0);
      cmd(C_LOAD, 8'h3C);
      check("ovr_sovr", SOVR, 1);
      check("ovr_sful", SFUL, 1);
      n = cyc;
      // Line levels 0,1,0,1,0,0,1,0,1 then stop (parity of A5 is also 1)
      exp_q.push_back('{11'b11_1010_0101_0, 1'b0, n + 2});
      cmd(C_GO, 8'h00);
      check("go_latency_sbsy", SBSY, 1);
      check("go_latency_sdwr", SDWR, 0);
      drain("drain_a5", 200);
      check("sovr_sticky", SOVR, 1);
      check("sful_after_send", SFUL, 0);
      cmd(C_ABORT, 8'h00);
      check("abort_clr_sovr", SOVR, 0);

      // GO before data, then back-to-back frames via double buffering
      cmd(C_GO, 8'h00);
      tick(8);
      check("go_no_data_idle", SBSY, 0);
      n = cyc; s = n + 2;
      exp_q.push_back('{frame_of(8'h01), 1'b0, s});
      cmd(C_LOAD, 8'h01);
      check("load_after_go_sbsy", SBSY, 1);
      wait_cyc(s + 6);
      exp_q.push_back('{frame_of(8'h80), 1'b0, s + NB * CPB + 1});
      cmd(C_LOAD, 8'h80);
      check("dbuf_sful", SFUL, 1);
      check("dbuf_sovr", SOVR, 0);
      cmd(C_GO, 8'h00);
      drain("drain_b2b", 300);

      // LOAD on the IDLE->START edge: shifter gets old byte, new byte held, no overrun
      cmd(C_LOAD, 8'h11);
      n = cyc; s = n + 2;
      exp_q.push_back('{frame_of(8'h11), 1'b0, s});
      cmd(C_GO, 8'h00);
      wait_cyc(s + 2);
      s2 = s + NB * CPB + 1;
      exp_q.push_back('{frame_of(8'h22), 1'b0, s2});
      cmd(C_LOAD, 8'h22);
      cmd(C_GO, 8'h00);
      wait_cyc(s2 - 1);
      cmd(C_LOAD, 8'h33);
      check("start_edge_sful", SFUL, 1);
      check("start_edge_sovr", SOVR, 0);
      exp_q.push_back('{frame_of(8'h33), 1'b0, s2 + NB * CPB + 1});
      cmd(C_GO, 8'h00);
      drain("drain_start_edge", 400);

      // ABORT inside the third data bit
      cmd(C_LOAD, 8'h5A);
      n = cyc; s = n + 2;
      exp_q.push_back('{frame_of(8'h5A), 1'b1, s});
      cmd(C_GO, 8'h00);
      wait_cyc(s + 1);
      cmd(C_LOAD, 8'h77);
      cmd(C_LOAD, 8'h66);
      cmd(C_GO, 8'h00);
      check("pre_abort_sful", SFUL, 1);
      check("pre_abort_sovr", SOVR, 1);
      wait_cyc(s + 3 * CPB + 1);
      bus(1'b0, 1'b0, 1'b1, 1'b0, C_ABORT, 8'h00, 1);
      check("abort_sdwr", SDWR, 1);
      check("abort_sbsy", SBSY, 0);
      check("abort_sful", SFUL, 0);
      check("abort_sovr", SOVR, 0);
      tick(2 * NB * CPB);
      check("abort_no_resend", SBSY, 0);
      check("abort_queue_empty", exp_q.size(), 0);

      // Reset held two cycles in the middle of a frame
      cmd(C_LOAD, 8'hC3);
      n = cyc; s = n + 2;
      exp_q.push_back('{frame_of(8'hC3), 1'b1, s});
      cmd(C_GO, 8'h00);
      wait_cyc(s + 2);
      cmd(C_LOAD, 8'h44);
      cmd(C_LOAD, 8'h55);
      check("pre_rst_sful", SFUL, 1);
      check("pre_rst_sovr", SOVR, 1);
      wait_cyc(s + 20);
      rst = 1'b1;
      tick(1);
      check("midrst_sdwr", SDWR, 1);
      check("midrst_sbsy", SBSY, 0);
      check("midrst_sful", SFUL, 0);
      check("midrst_sovr", SOVR, 0);
      tick(1);
      rst = 1'b0;
      tick(2 * NB * CPB);
      check("rst_no_resend", SBSY, 0);
      check("rst_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
